// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32 control path: opcodes, FSM states and
// datapath mux/ALU select encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpCtz    = 7'b1001011;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StExecR, StExecI, StMemAddr, StMemRd,
    StMemWb, StMemWr, StBranch, StCtz, StAluWb, StTrap
  } state_e;

  localparam logic [1:0] AluOpAdd    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpFunct  = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcARs1   = 2'b01;
  localparam logic [1:0] SrcAOldPc = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

  // First execute-phase state for a given opcode; anything unknown traps.
  function automatic state_e decode_next(logic [6:0] op);
    case (op)
      OpR:             return StExecR;
      OpI:             return StExecI;
      OpLoad, OpStore: return StMemAddr;
      OpBranch:        return StBranch;
      OpCtz:           return StCtz;
      default:         return StTrap;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module ctrl_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_en,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (count_en) cycle_q <= cycle_q + CNT_W'(1);
      if (retire)   instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV32 core with the iterative CTZ extension. Outputs are
// Moore decodes of the state, except the FETCH completion strobes which follow mem_ready.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CTZ_STEP = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             ctz_done,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             ctz,
  output logic             ctz_busy,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int unsigned CtzCycles = XLEN / CTZ_STEP;
  localparam int unsigned CtzW      = (CtzCycles > 1) ? $clog2(CtzCycles) : 1;

  state_e          state_q, state_d;
  logic [CtzW-1:0] ctz_cnt_q, ctz_cnt_d;
  logic            from_ctz_q;
  logic            retire, count_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ctz_cnt_q  <= '0;
      from_ctz_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctz_cnt_q  <= ctz_cnt_d;
      // ALU_WB is reached only from EXEC_R, EXEC_I or CTZ, so one cycle of history suffices.
      from_ctz_q <= (state_q == StCtz);
    end
  end

  always_comb begin
    state_d       = state_q;
    ctz_cnt_d     = ctz_cnt_q;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = SrcAPc;
    alu_src_b     = SrcBRs2;
    alu_op        = AluOpAdd;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ctz           = 1'b0;
    ctz_busy      = 1'b0;
    illegal       = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = SrcAPc;
          alu_src_b = SrcBFour;
          alu_op    = AluOpAdd;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        state_d   = decode_next(opcode);
        if (state_d == StCtz) ctz_cnt_d = CtzW'(CtzCycles - 1);
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBRs2;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        state_d   = StAluWb;
      end
      StMemAddr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        state_d   = (opcode == OpLoad) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
        retire     = 1'b1;
      end
      StMemWr: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StBranch: begin
        alu_src_a     = SrcARs1;
        alu_src_b     = SrcBRs2;
        alu_op        = AluOpBranch;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        state_d       = StFetch;
        retire        = 1'b1;
      end
      StCtz: begin
        ctz      = 1'b1;
        ctz_busy = 1'b1;
        alu_op   = AluOpFunct;
        if (ctz_done || ctz_cnt_q == '0) state_d = StAluWb;
        else ctz_cnt_d = ctz_cnt_q - CtzW'(1);
      end
      StAluWb: begin
        reg_write = 1'b1;
        ctz       = from_ctz_q;
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StTrap: illegal = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  assign count_en = (state_q != StIdle);

  ctrl_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en   (count_en),
    .retire     (retire),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each instruction is expanded into its expected per-cycle output sequence,
// which is then replayed against the DUT cycle by cycle.
module tb_multicycle_control;

  localparam int unsigned XLEN = 32, CTZ_STEP = 4, CNT_W = 32;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_CTZ = 7'b1001011;
  localparam int KFetch = 0, KDecode = 1, KExecR = 2, KExecI = 3, KMemAddr = 4, KMemRd = 5;
  localparam int KMemWb = 6, KMemWr = 7, KBranch = 8, KCtz = 9, KAluWb = 10, KTrap = 11;

  typedef struct packed {
    logic       mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic       pc_source;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       reg_write, mem_to_reg, ctz, ctz_busy, illegal;
  } ctl_t;

  typedef struct packed {
    logic mem_ready, ctz_done, counts, retires;
    ctl_t exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic mem_ready = 1'b0, ctz_done = 1'b0;
  logic mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic reg_write, mem_to_reg, ctz, ctz_busy, illegal;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  ctl_t act;

  vec_t q[$];
  logic [CNT_W-1:0] exp_cycle, exp_inst, chk_cycle, chk_inst;
  int checks = 0, failures = 0;
  int busy_seen = 0, pwc_seen = 0, rd_seen = 0, mark;

  always #5 clk = ~clk;

  assign act = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, ctz, ctz_busy,
                illegal};

  multicycle_control #(
    .XLEN(XLEN), .CTZ_STEP(CTZ_STEP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .ctz_done(ctz_done),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .ctz(ctz), .ctz_busy(ctz_busy),
    .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // Per-step output table; f is the FETCH mem_ready gate or the ALU_WB "came from CTZ" flag.
  function automatic ctl_t ctl(int s, logic f);
    ctl_t c = '0;
    case (s)
      KFetch: begin
        c.mem_req = 1'b1; c.mem_read = 1'b1;
        if (f) begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      end
      KDecode:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
      KExecR:   begin c.alu_src_a = 2'b01; c.alu_op = 2'b10; end
      KExecI, KMemAddr: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      KMemRd:   begin c.mem_req = 1'b1; c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      KMemWb:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      KMemWr:   begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      KBranch: begin
        c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 1'b1;
      end
      KCtz:     begin c.ctz = 1'b1; c.ctz_busy = 1'b1; c.alu_op = 2'b10; end
      KAluWb:   begin c.reg_write = 1'b1; c.ctz = f; end
      KTrap:    c.illegal = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic void push(logic mr, logic cd, logic ret, ctl_t e);
    vec_t v;
    v.mem_ready = mr; v.ctz_done = cd; v.counts = 1'b1; v.retires = ret; v.exp = e;
    q.push_back(v);
  endfunction

  // Expand one instruction. mem_ready/ctz_done are driven high wherever they must be ignored.
  function automatic void add_instr(logic [6:0] op, int fwait, int mwait, int ctz_at);
    int n;
    for (int i = 0; i < fwait; i++) push(1'b0, 1'b1, 1'b0, ctl(KFetch, 1'b0));
    push(1'b1, 1'b1, 1'b0, ctl(KFetch, 1'b1));
    push(1'b1, 1'b1, 1'b0, ctl(KDecode, 1'b0));
    case (op)
      OP_R: begin push(1'b1, 1'b1, 1'b0, ctl(KExecR, 1'b0)); push(1'b1, 1'b1, 1'b1, ctl(KAluWb, 1'b0)); end
      OP_I: begin push(1'b1, 1'b1, 1'b0, ctl(KExecI, 1'b0)); push(1'b1, 1'b1, 1'b1, ctl(KAluWb, 1'b0)); end
      OP_LD: begin
        push(1'b1, 1'b1, 1'b0, ctl(KMemAddr, 1'b0));
        for (int i = 0; i < mwait; i++) push(1'b0, 1'b1, 1'b0, ctl(KMemRd, 1'b0));
        push(1'b1, 1'b1, 1'b0, ctl(KMemRd, 1'b0));
        push(1'b1, 1'b1, 1'b1, ctl(KMemWb, 1'b0));
      end
      OP_ST: begin
        push(1'b1, 1'b1, 1'b0, ctl(KMemAddr, 1'b0));
        for (int i = 0; i < mwait; i++) push(1'b0, 1'b1, 1'b0, ctl(KMemWr, 1'b0));
        push(1'b1, 1'b1, 1'b1, ctl(KMemWr, 1'b0));
      end
      OP_BR: push(1'b1, 1'b1, 1'b1, ctl(KBranch, 1'b0));
      OP_CTZ: begin
        n = (ctz_at == 0) ? int'(XLEN / CTZ_STEP) : ctz_at;
        for (int i = 0; i < n; i++)
          push(1'b1, (ctz_at != 0 && i == n - 1), 1'b0, ctl(KCtz, 1'b0));
        push(1'b1, 1'b1, 1'b1, ctl(KAluWb, 1'b1));
      end
      default: ;
    endcase
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one vector just after the rising edge, compare on the falling edge.
  task automatic step(vec_t v);
    mem_ready = v.mem_ready;
    ctz_done  = v.ctz_done;
    chk_cycle = exp_cycle;
    chk_inst  = exp_inst;
    if (v.counts)  exp_cycle++;
    if (v.retires) exp_inst++;
    @(negedge clk);
    check("ctl", 64'(act), 64'(v.exp));
    check("cycle_cnt", 64'(cycle_cnt), 64'(chk_cycle));
    check("instret_cnt", 64'(instret_cnt), 64'(chk_inst));
    if (ctz_busy) busy_seen++;
    if (pc_write_cond) pwc_seen++;
    if (mem_req && mem_read && i_or_d) rd_seen++;
  endtask

  task automatic run(int max);
    int n = 0;
    while (q.size() > 0 && n < max) begin
      @(posedge clk);
      #1;
      step(q.pop_front());
      n++;
    end
  endtask

  task automatic do_reset();
    vec_t idle = '0;
    q.delete();
    rst_n = 1'b0;
    exp_cycle = '0;
    exp_inst  = '0;
    #1;
    check("reset_ctl", 64'(act), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(idle);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    opcode = OP_R; add_instr(OP_R, 0, 0, 0); run(100);
    check("r_wb_reg_write", 64'(reg_write), 64'd1);
    check("r_cycle_at_wb", 64'(cycle_cnt), 64'd3);

    opcode = OP_LD; mark = rd_seen; add_instr(OP_LD, 1, 3, 0); run(100);
    check("ld_rd_cycles", 64'(rd_seen - mark), 64'd4);
    check("ld_wb_mem_to_reg", 64'(mem_to_reg), 64'd1);
    check("ld_instret_at_wb", 64'(instret_cnt), 64'd1);

    opcode = OP_I;  add_instr(OP_I, 0, 0, 0);  run(100);
    opcode = OP_ST; add_instr(OP_ST, 0, 1, 0); run(100);

    opcode = OP_BR; mark = pwc_seen; add_instr(OP_BR, 0, 0, 0); run(100);
    check("br_pwc_cycles", 64'(pwc_seen - mark), 64'd1);

    opcode = OP_CTZ; mark = busy_seen; add_instr(OP_CTZ, 0, 0, 0); run(100);
    check("ctz_full_cycles", 64'(busy_seen - mark), 64'd8);
    mark = busy_seen; add_instr(OP_CTZ, 2, 0, 2); run(100);
    check("ctz_early_cycles", 64'(busy_seen - mark), 64'd2);

    // Abandon a store mid-wait: fetch, decode, addr, then two MEM_WR wait cycles.
    opcode = OP_ST; add_instr(OP_ST, 0, 5, 0); run(5);
    #1;
    check("st_wait_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", 64'(act), 64'd0);
    check("async_rst_cycle", 64'(cycle_cnt), 64'd0);
    check("async_rst_instret", 64'(instret_cnt), 64'd0);
    do_reset();
    opcode = OP_R; add_instr(OP_R, 0, 0, 0); run(100);

    opcode = 7'b1111111; add_instr(opcode, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b0, ctl(KTrap, 1'b0));
    run(100);
    check("trap_illegal", 64'(illegal), 64'd1);
    check("trap_mem_req", 64'(mem_req), 64'd0);
    check("trap_cycle", 64'(cycle_cnt), 64'd9);
    do_reset();
    check("post_trap_illegal", 64'(illegal), 64'd0);
    opcode = OP_BR; add_instr(OP_BR, 0, 0, 0); run(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
